// File: rtl/axi_stream_wr_master.sv
// axi_stream_wr_master
//   Accepts a (byte address, beat count, id) command and moves that many beats
//   from a valid/ready data stream into AXI4 INCR write bursts. Only one burst
//   is outstanding at a time. Bursts never cross a 4 KiB page. Each burst is
//   sized to the smallest of: the beats remaining, MAX_BURST, and the beats
//   left in the page.
// Ports
//   clk, rst            clock, asynchronous active-low reset
//   cmd_*               command handshake (addr, len in beats, id)
//   s_data/valid/ready  write-data stream, passed straight through to W
//   m_axi_aw*/w*/b*     AXI4 write-channel master
//   busy                a command is in flight
//   done                one-cycle completion pulse
//   error               OR of non-OKAY bresp over the command; valid with done
// The page-boundary logic assumes ADDR_WIDTH >= 12.
module axi_stream_wr_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int MAX_BURST  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [CNT_WIDTH-1:0]  cmd_len,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [ID_WIDTH-1:0]   m_axi_awid,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic [LEN_WIDTH-1:0]  m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic [1:0]            m_axi_awlock,
  output logic [3:0]            m_axi_awcache,
  output logic [2:0]            m_axi_awprot,
  output logic [3:0]            m_axi_awqos,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [STRB_WIDTH-1:0] m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [ID_WIDTH-1:0]   m_axi_bid,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int SZ = $clog2(STRB_WIDTH);
  localparam int BW = 32;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_e;

  state_e                state_q, state_d;
  logic                  run_q, run_d;     // low until the first edge after reset
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  logic                  acc_q, acc_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic [BW-1:0]         to_4k, burst;
  logic [CNT_WIDTH-1:0]  rem_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic                  cmd_hs, w_hs, b_err;

  // The response id is not checked; responses are matched by order alone.
  logic unused_bid;
  assign unused_bid = ^m_axi_bid;

  // addr_q and rem_q only change on the B handshake. So the burst size stays
  // constant from ADDR through RESP and can be derived combinationally.
  always_comb begin
    to_4k = (BW'(4096) - BW'(addr_q[11:0])) >> SZ;
    burst = BW'(rem_q);
    if (burst > BW'(MAX_BURST)) burst = BW'(MAX_BURST);
    if (burst > to_4k)          burst = to_4k;
  end

  assign rem_nxt  = rem_q - CNT_WIDTH'(burst);
  assign addr_nxt = addr_q + ADDR_WIDTH'(burst << SZ);
  assign cmd_hs   = cmd_valid && cmd_ready;
  assign w_hs     = m_axi_wvalid && m_axi_wready;
  assign b_err    = m_axi_bresp != 2'b00;

  assign cmd_ready     = run_q && (state_q == IDLE);
  assign busy          = state_q != IDLE;
  assign done          = done_q;
  assign error         = err_q;

  assign m_axi_awid    = id_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = LEN_WIDTH'(burst - BW'(1));
  assign m_axi_awsize  = 3'(SZ);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awlock  = 2'b00;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awqos   = 4'b0000;
  assign m_axi_awvalid = state_q == ADDR;

  assign m_axi_wdata   = s_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = (state_q == DATA) && s_valid;
  assign m_axi_wlast   = (state_q == DATA) && (beat_q == m_axi_awlen);
  assign s_ready       = (state_q == DATA) && m_axi_wready;
  assign m_axi_bready  = state_q == RESP;

  always_comb begin
    state_d = state_q;
    run_d   = 1'b1;
    addr_d  = addr_q;
    rem_d   = rem_q;
    id_d    = id_q;
    beat_d  = beat_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (cmd_hs) begin
        addr_d = cmd_addr & ~ADDR_WIDTH'(STRB_WIDTH - 1);
        rem_d  = cmd_len;
        id_d   = cmd_id;
        acc_d  = 1'b0;
        if (cmd_len == '0) done_d  = 1'b1;  // empty command: complete without bus traffic
        else               state_d = ADDR;
      end
      ADDR: if (m_axi_awready) begin
        state_d = DATA;
        beat_d  = '0;
      end
      DATA: if (w_hs) begin
        if (m_axi_wlast) state_d = RESP;
        else             beat_d  = beat_q + LEN_WIDTH'(1);
      end
      RESP: if (m_axi_bvalid) begin
        acc_d  = acc_q | b_err;
        rem_d  = rem_nxt;
        addr_d = addr_nxt;
        if (rem_nxt == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          err_d   = acc_q | b_err;
        end else begin
          state_d = ADDR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      run_q   <= 1'b0;
      addr_q  <= '0;
      rem_q   <= '0;
      id_q    <= '0;
      beat_q  <= '0;
      acc_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      id_q    <= id_d;
      beat_q  <= beat_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/axi_stream_wr_master.md
AXI_STREAM_WR_MASTER -- requirements
Module: axi_stream_wr_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: AXI and stream data width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 16: AXI byte-address width.
REQ-003 SHALL have parameter STRB_WIDTH, default DATA_WIDTH/8: bytes per beat, power of two.
REQ-004 SHALL have parameter ID_WIDTH, default 8: AXI ID width.
REQ-005 SHALL have parameter LEN_WIDTH, default 8: awlen width.
REQ-006 SHALL have parameter MAX_BURST, default 16: maximum beats per burst, 1..2**LEN_WIDTH.
REQ-007 SHALL have parameter CNT_WIDTH, default 16: command beat-count width.
REQ-008 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-009 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-010 SHALL have ports cmd_addr (input, ADDR_WIDTH), cmd_len (input, CNT_WIDTH) and cmd_id (input, ID_WIDTH): start byte address, beat count and AXI ID.
REQ-011 SHALL have ports cmd_valid (input, 1) and cmd_ready (output, 1): command handshake.
REQ-012 SHALL have ports s_data (input, DATA_WIDTH), s_valid (input, 1) and s_ready (output, 1): write-data stream.
REQ-013 SHALL have m_axi_aw* outputs: awid (ID_WIDTH), awaddr (ADDR_WIDTH), awlen (LEN_WIDTH), awsize (3), awburst (2), awlock (2), awcache (4), awprot (3), awqos (4) and awvalid (1); input awready (1).
REQ-014 SHALL have m_axi_w* outputs: wdata (DATA_WIDTH), wstrb (STRB_WIDTH), wlast (1) and wvalid (1); input wready (1).
REQ-015 SHALL have m_axi_b* inputs: bid (ID_WIDTH), bresp (2) and bvalid (1); output bready (1).
REQ-016 SHALL have outputs busy (1), done (1, one-cycle pulse) and error (1, valid while done=1).

Function
REQ-017 SHALL implement states IDLE, ADDR, DATA and RESP; busy=1 whenever the state is not IDLE.
REQ-018 SHALL drive cmd_ready=1 only in IDLE; on cmd_valid&&cmd_ready it SHALL latch cmd_addr with its low log2(STRB_WIDTH) bits cleared, cmd_len, cmd_id, and clear the error accumulator.
REQ-019 SHALL, when cmd_len=0 is accepted, pulse done with error=0 on the next cycle, stay in IDLE and issue no AXI traffic.
REQ-020 SHALL, when cmd_len>0 is accepted, enter ADDR so that awvalid=1 on the cycle after acceptance.
REQ-021 SHALL size each burst as min(remaining beats, MAX_BURST, beats left before the next 4 KiB boundary), drive awlen=burst-1, and never cross 4 KiB.
REQ-022 SHALL drive awsize=log2(STRB_WIDTH), awburst=2'b01 (INCR), awlock=0, awcache=4'b0011, awprot=0, awqos=0 and awid=latched cmd_id.
REQ-023 SHALL hold all aw* outputs stable while awvalid=1 && awready=0, and move to DATA on the awready handshake.
REQ-024 SHALL, in DATA, drive m_axi_wvalid=s_valid, s_ready=m_axi_wready, wdata=s_data and wstrb all ones; outside DATA, s_ready=0 and wvalid=0.
REQ-025 SHALL count W beats and drive wlast=1 exactly on beat burst-1; after that beat handshakes it SHALL enter RESP.
REQ-026 SHALL drive bready=1 only in RESP; on bvalid it SHALL OR (bresp!=2'b00) into the error accumulator.
REQ-027 SHALL, on that B handshake, subtract burst from remaining and add burst*STRB_WIDTH to the address (modulo 2**ADDR_WIDTH).
REQ-028 SHALL, after the B handshake, return to ADDR if remaining>0; otherwise it SHALL pulse done for one cycle with error=accumulator and return to IDLE.
REQ-029 SHALL have at most one burst outstanding; a new AW SHALL NOT be issued before the previous B handshake.
REQ-030 SHALL ignore a bid mismatch and any bvalid outside RESP.

Reset
REQ-031 SHALL, on rst low, immediately force state IDLE and drive awvalid=0, wvalid=0, bready=0, s_ready=0, done=0, error=0, busy=0 and cmd_ready=0.
REQ-032 SHALL drive cmd_ready=1 on the first clock edge after rst deasserts.
REQ-033 SHALL abandon any in-flight command on reset mid-operation, with no completion pulse; the downstream slave is reset together with this block.

Verification
REQ-034 SHALL be verified for: cmd_addr=0x0100, cmd_len=4 -> one AW with awaddr=0x0100, awlen=3, four W beats, wlast on beat 4, done one cycle after the B handshake, error=0.
REQ-035 SHALL be verified for: cmd_addr=0x0000, cmd_len=40, MAX_BURST=16 -> AWs at 0x0000/awlen 15, 0x0040/awlen 15 and 0x0080/awlen 7, in that order.
REQ-036 SHALL be verified for: cmd_addr=0x0FF8, cmd_len=4, DATA_WIDTH=32 -> AW 0x0FF8/awlen 1, then AW 0x1000/awlen 1.
REQ-037 SHALL be verified for: 64 beats with random s_valid and wready gaps into a RAM slave -> read-back matches the stream exactly, with no dropped or duplicated beats.
REQ-038 SHALL be verified for: bresp=2'b10 on the 2nd of 3 bursts -> all 3 bursts complete and done has error=1; the next command completes with error=0.
REQ-039 SHALL be verified for: rst low mid-DATA -> all valid outputs drop within the same cycle, no done pulse, and a subsequent cmd_len=0 gives done with error=0.
